alu_writeback: RTL and testbench



---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_writeback_if.sv | 27 ++
 rtl/alu_writeback.sv | 117 +++++++++++
 tb/tb_alu_writeback.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants, writeback FSM states and write-op decode for alu_writeback
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR1  = 2'd1,
    WR2  = 2'd2
  } wb_state_t;

  function automatic logic is_write_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
           (op == OP_DIV) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// rtl/alu_writeback_if.sv - execute-to-writeback result handshake
interface alu_writeback_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int OP_W   = 3
) ();

  logic              InValid;
  logic              InReady;
  logic [OP_W-1:0]   InOp;
  logic [DATA_W-1:0] InRes1;
  logic [DATA_W-1:0] InRes2;
  logic              InZero;
  logic [ADDR_W-1:0] InDestA;
  logic [ADDR_W-1:0] InDestB;

  modport master (
    output InValid, InOp, InRes1, InRes2, InZero, InDestA, InDestB,
    input  InReady
  );

  modport slave (
    input  InValid, InOp, InRes1, InRes2, InZero, InDestA, InDestB,
    output InReady
  );

endinterface

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - registered ALU result stage driving the register-file write port
// Optional macro WB_BYPASS_EN adds the operand-forwarding outputs.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int OP_W   = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  alu_writeback_if.slave    ex,
  output logic              RegWrEn,
  output logic [ADDR_W-1:0] RegWrAddr,
  output logic [DATA_W-1:0] RegWrData,
  output logic              ZeroFlag
`ifdef WB_BYPASS_EN
  ,
  output logic              FwdValid,
  output logic [ADDR_W-1:0] FwdAddr,
  output logic [DATA_W-1:0] FwdData,
  output logic [ADDR_W-1:0] FwdAddr2,
  output logic [DATA_W-1:0] FwdData2
`endif
);

  wb_state_t         state_q, state_d;
  logic              div_q, div_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              zero_q, zero_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] destb_q, destb_d;
  logic              accept;

  // Only the quotient cycle of a DIV blocks: the remainder write owns the port next cycle.
  assign ex.InReady = !((state_q == WR1) && div_q);
  assign accept     = ex.InValid && ex.InReady;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    zero_d    = zero_q;
    rem_d     = rem_q;
    destb_d   = destb_q;

    if ((state_q == WR1) && div_q) begin
      state_d   = WR2;
      div_d     = 1'b0;
      wr_en_d   = 1'b1;
      wr_addr_d = destb_q;
      wr_data_d = rem_q;
    end else if (accept) begin
      zero_d = ex.InZero;
      if (is_write_op(ex.InOp)) begin
        state_d   = WR1;
        div_d     = (ex.InOp == OP_DIV);
        wr_en_d   = 1'b1;
        wr_addr_d = ex.InDestA;
        wr_data_d = ex.InRes1;
        if (ex.InOp == OP_DIV) begin
          rem_d   = ex.InRes2;
          destb_d = ex.InDestB;
        end
      end else begin
        state_d = IDLE;
        div_d   = 1'b0;
        wr_en_d = 1'b0;
      end
    end else begin
      state_d = IDLE;
      div_d   = 1'b0;
      wr_en_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      div_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      zero_q    <= 1'b0;
      rem_q     <= '0;
      destb_q   <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      zero_q    <= zero_d;
      rem_q     <= rem_d;
      destb_q   <= destb_d;
    end
  end

  assign RegWrEn   = wr_en_q;
  assign RegWrAddr = wr_addr_q;
  assign RegWrData = wr_data_q;
  assign ZeroFlag  = zero_q;

`ifdef WB_BYPASS_EN
  // The second pair exposes the pending remainder while the quotient is being written.
  assign FwdValid = wr_en_q;
  assign FwdAddr  = wr_addr_q;
  assign FwdData  = wr_data_q;
  assign FwdAddr2 = destb_q;
  assign FwdData2 = rem_q;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - directed self-checking bench for alu_writeback
module tb_alu_writeback;

  logic        Clk;
  logic        Reset;
  logic        RegWrEn;
  logic [3:0]  RegWrAddr;
  logic [15:0] RegWrData;
  logic        ZeroFlag;
`ifdef WB_BYPASS_EN
  logic        FwdValid;
  logic [3:0]  FwdAddr;
  logic [15:0] FwdData;
  logic [3:0]  FwdAddr2;
  logic [15:0] FwdData2;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] rf [16];

  alu_writeback_if #(.DATA_W(16), .ADDR_W(4), .OP_W(3)) ex_if ();

  alu_writeback #(.DATA_W(16), .ADDR_W(4), .OP_W(3)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .ex        (ex_if),
    .RegWrEn   (RegWrEn),
    .RegWrAddr (RegWrAddr),
    .RegWrData (RegWrData),
    .ZeroFlag  (ZeroFlag)
`ifdef WB_BYPASS_EN
    ,
    .FwdValid  (FwdValid),
    .FwdAddr   (FwdAddr),
    .FwdData   (FwdData),
    .FwdAddr2  (FwdAddr2),
    .FwdData2  (FwdData2)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (RegWrEn) rf[RegWrAddr] <= RegWrData;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] r1,
                       input logic [15:0] r2, input logic z, input logic [3:0] da,
                       input logic [3:0] db);
    ex_if.InValid = v;
    ex_if.InOp    = op;
    ex_if.InRes1  = r1;
    ex_if.InRes2  = r2;
    ex_if.InZero  = z;
    ex_if.InDestA = da;
    ex_if.InDestB = db;
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 16'h0, 16'h0, 1'b0, 4'h0, 4'h0);
  endtask

  task automatic check_wr(input string name, input logic en, input logic [3:0] addr,
                          input logic [15:0] data, input logic z, input logic rdy);
    checks++;
    if (RegWrEn !== en || (en && (RegWrAddr !== addr || RegWrData !== data)) ||
        ZeroFlag !== z || ex_if.InReady !== rdy) begin
      errors++;
      $display("FAIL %s: got en=%b addr=%h data=%h zf=%b rdy=%b, expected en=%b addr=%h data=%h zf=%b rdy=%b",
               name, RegWrEn, RegWrAddr, RegWrData, ZeroFlag, ex_if.InReady,
               en, addr, data, z, rdy);
    end
  endtask

  task automatic test_reset();
    idle();
    Reset = 1'b0;
    step();
    step();
    checks++;
    if (RegWrEn !== 1'b0 || RegWrAddr !== 4'h0 || RegWrData !== 16'h0 ||
        ZeroFlag !== 1'b0 || ex_if.InReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: got en=%b addr=%h data=%h zf=%b rdy=%b, expected 0 0 0000 0 1",
               RegWrEn, RegWrAddr, RegWrData, ZeroFlag, ex_if.InReady);
    end
    Reset = 1'b1;
    step();
    check_wr("idle_after_reset", 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 3'b010, 16'h0005, 16'hDEAD, 1'b0, 4'd3, 4'd9);
    step();
    drive(1'b1, 3'b011, 16'h0000, 16'hBEEF, 1'b1, 4'd4, 4'd9);
    check_wr("add_write_r3", 1'b1, 4'd3, 16'h0005, 1'b0, 1'b1);
    step();
    idle();
    check_wr("sub_write_r4", 1'b1, 4'd4, 16'h0000, 1'b1, 1'b1);
    step();
    check_wr("no_second_write_after_sub", 1'b0, 4'd0, 16'h0, 1'b1, 1'b1);
  endtask

  task automatic test_div();
    drive(1'b1, 3'b101, 16'h0003, 16'h0002, 1'b0, 4'd1, 4'd2);
    step();
    drive(1'b1, 3'b010, 16'h0000, 16'h1234, 1'b1, 4'd7, 4'd0);
    check_wr("div_quotient_r1", 1'b1, 4'd1, 16'h0003, 1'b0, 1'b0);
    step();
    check_wr("div_remainder_r2", 1'b1, 4'd2, 16'h0002, 1'b0, 1'b1);
    step();
    idle();
    check_wr("held_add_after_div", 1'b1, 4'd7, 16'h0000, 1'b1, 1'b1);
    step();
    check_wr("idle_after_div_add", 1'b0, 4'd0, 16'h0, 1'b1, 1'b1);
  endtask

  task automatic test_div_same_dest();
    drive(1'b1, 3'b101, 16'h0007, 16'h0001, 1'b0, 4'd5, 4'd5);
    step();
    idle();
    check_wr("div_same_dest_q", 1'b1, 4'd5, 16'h0007, 1'b0, 1'b0);
    step();
    check_wr("div_same_dest_r", 1'b1, 4'd5, 16'h0001, 1'b0, 1'b1);
    step();
    checks++;
    if (rf[5] !== 16'h0001) begin
      errors++;
      $display("FAIL div_same_dest_final: got r5=%h expected 0001", rf[5]);
    end
  endtask

  task automatic test_no_write();
    drive(1'b1, 3'b000, 16'h5555, 16'h0, 1'b1, 4'd8, 4'd0);
    step();
    drive(1'b1, 3'b111, 16'hAAAA, 16'h0, 1'b0, 4'd9, 4'd0);
    check_wr("nop000_zero_set", 1'b0, 4'd0, 16'h0, 1'b1, 1'b1);
    step();
    idle();
    check_wr("nop111_zero_clear", 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_div();
    drive(1'b1, 3'b101, 16'h0011, 16'h0022, 1'b1, 4'd10, 4'd11);
    step();
    idle();
    check_wr("mid_div_wr1", 1'b1, 4'd10, 16'h0011, 1'b1, 1'b0);
    Reset = 1'b0;
    #1;
    check_wr("async_reset_clears", 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
    step();
    Reset = 1'b1;
    step();
    check_wr("no_remainder_after_reset", 1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
    checks++;
    if (rf[11] === 16'h0022) begin
      errors++;
      $display("FAIL dropped_remainder: got r11=%h expected not 0022", rf[11]);
    end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    drive(1'b1, 3'b100, 16'h0010, 16'h0, 1'b0, 4'd6, 4'd0);
    step();
    idle();
    check_wr("mul_write_r6", 1'b1, 4'd6, 16'h0010, 1'b0, 1'b1);
    checks++;
    if (FwdValid !== 1'b1 || FwdAddr !== 4'd6 || FwdData !== 16'h0010) begin
      errors++;
      $display("FAIL bypass_mul: got v=%b addr=%h data=%h expected 1 6 0010",
               FwdValid, FwdAddr, FwdData);
    end
    drive(1'b1, 3'b101, 16'h0004, 16'h0003, 1'b0, 4'd12, 4'd13);
    step();
    idle();
    checks++;
    if (FwdValid !== 1'b1 || FwdAddr2 !== 4'd13 || FwdData2 !== 16'h0003) begin
      errors++;
      $display("FAIL bypass_div_pair2: got v=%b addr2=%h data2=%h expected 1 d 0003",
               FwdValid, FwdAddr2, FwdData2);
    end
    step();
    step();
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 16'h0;
    Reset = 1'b1;
    idle();
    #2;
    test_reset();
    test_back_to_back();
    test_div();
    test_div_same_dest();
    test_no_write();
    test_reset_mid_div();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

endmodule
